// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter plus a three-state
// launcher driving the tx_start / tx_din / tx_done_tick handshake.
// Optional feature macro: UART_TX_FEEDER_OVF_EN enables the sticky overflow flag.
// With the macro undefined, overflow is tied low and ovf_clr is ignored.
module uart_tx_feeder #(
    parameter int ADDR_W = 4,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DW-1:0]     wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              tx_start,
    output logic [DW-1:0]     tx_din,
    input  logic              tx_done_tick,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t              state;
    logic [DW-1:0]       mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                push;
    logic                pop;

    // Flags come straight from the count register so they never glitch on inputs.
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A pop only frees space for the next cycle; a write while full is lost.
    assign push = wr_en && !full;
    assign pop  = (state == S_IDLE) && !empty;

    assign tx_start = (state == S_LAUNCH);
    assign busy     = (state != S_IDLE) || !empty;

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Write pointer and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Launch FSM: pop into tx_din, pulse tx_start for one cycle, wait for done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            tx_din <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        tx_din <= mem[rd_ptr];
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_tick) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic ovf_q;

    // Sticky write-while-full flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule
